// File: rtl/oreg_drain_ctrl_pkg.sv
// Shared definitions for the output-register drain controller: word width,
// saturation limits, FSM state encoding and the per-column saturation function.
package oreg_drain_ctrl_pkg;

    // Wide enough to hold any sign-extended accumulator this block is built with
    localparam int SAT_BITS = 64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    function automatic int word_width(input int fWidth, input int iWidth);
        return fWidth + iWidth;
    endfunction

    function automatic logic signed [SAT_BITS-1:0] MAX_W(input int w);
        logic signed [SAT_BITS-1:0] one;
        one = SAT_BITS'(1);
        return (one <<< (w - 1)) - one;
    endfunction

    function automatic logic signed [SAT_BITS-1:0] MIN_W(input int w);
        logic signed [SAT_BITS-1:0] one;
        one = SAT_BITS'(1);
        return -(one <<< (w - 1));
    endfunction

    // Clamp a sign-extended sum into a w-bit signed word; callers keep the low w bits
    function automatic logic signed [SAT_BITS-1:0] saturate(
        input logic signed [SAT_BITS-1:0] sum,
        input int                         w
    );
        if (sum > MAX_W(w)) begin
            return MAX_W(w);
        end else if (sum < MIN_W(w)) begin
            return MIN_W(w);
        end
        return sum;
    endfunction

endpackage

// File: rtl/oreg_drain_ctrl_reg.sv
// One output-bank column: a write-enabled word register with asynchronous reset.
module oreg_drain_ctrl_reg #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         oreg_rst_i,
    input  logic         i_we,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk_i or posedge oreg_rst_i) begin
        if (oreg_rst_i) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/oreg_drain_ctrl.sv
// Captures one row of PE partial sums into a saturating register bank and
// drains it column by column onto a valid/ready stream.
module oreg_drain_ctrl
    import oreg_drain_ctrl_pkg::*;
#(
    parameter int F_WIDTH = 8,
    parameter int I_WIDTH = 8,
    parameter int G_BITS  = 4,
    parameter int N_COLS  = 4,
    localparam int W      = word_width(F_WIDTH, I_WIDTH),
    localparam int A      = W + G_BITS
) (
    input  logic              clk_i,
    input  logic              oreg_rst_i,
    input  logic              capture_i,
    input  logic [N_COLS*A-1:0] psum_i,
    output logic              capture_ready_o,
    output logic [W-1:0]      out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o,
    output logic              frame_done_o,
    output logic              overrun_o
);

    localparam int IDX_W = $clog2(N_COLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COLS - 1);
    localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(N_COLS - 2);

    logic [W-1:0]     w_satWord [N_COLS];
    logic [W-1:0]     w_regQ    [N_COLS];
    logic             w_capAccept;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic             r_last;
    logic             r_frameDone;
    logic             r_overrun;
    logic             r_capReady;

    assign w_capAccept = capture_i & r_capReady;

    for (genvar c = 0; c < N_COLS; c++) begin : gCol
        logic signed [SAT_BITS-1:0] w_sumExt;

        assign w_sumExt     = {{(SAT_BITS-A){psum_i[c*A + A - 1]}}, psum_i[c*A +: A]};
        assign w_satWord[c] = W'(saturate(w_sumExt, W));

        oreg_drain_ctrl_reg #(
            .W(W)
        ) uReg (
            .clk_i      (clk_i),
            .oreg_rst_i (oreg_rst_i),
            .i_we       (w_capAccept),
            .i_d        (w_satWord[c]),
            .o_q        (w_regQ[c])
        );
    end

    // Outputs are flops updated alongside the state so nothing reaches them from inputs
    always_ff @(posedge clk_i or posedge oreg_rst_i) begin
        if (oreg_rst_i) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_frameDone <= 1'b0;
            r_overrun   <= 1'b0;
            r_capReady  <= 1'b1;
        end else begin
            r_frameDone <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_capAccept) begin
                        r_state    <= ST_DRAIN;
                        r_idx      <= '0;
                        r_valid    <= 1'b1;
                        r_last     <= 1'b0;
                        r_capReady <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (capture_i) begin
                        r_overrun <= 1'b1;
                    end
                    if (out_ready_i) begin
                        if (r_idx == LAST_IDX) begin
                            r_state     <= ST_IDLE;
                            r_idx       <= '0;
                            r_valid     <= 1'b0;
                            r_last      <= 1'b0;
                            r_capReady  <= 1'b1;
                            r_frameDone <= 1'b1;
                        end else begin
                            r_idx  <= r_idx + 1'b1;
                            r_last <= (r_idx == PENULT_IDX);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data_o      = r_valid ? w_regQ[r_idx] : '0;
    assign out_valid_o     = r_valid;
    assign out_last_o      = r_last;
    assign frame_done_o    = r_frameDone;
    assign overrun_o       = r_overrun;
    assign capture_ready_o = r_capReady;

endmodule

// File: tb/tb_oreg_drain_ctrl.sv
// Directed bench for oreg_drain_ctrl: drain order, saturation, backpressure,
// overrun, back-to-back capture and asynchronous reset mid-drain.
module tb_oreg_drain_ctrl;

    localparam int F_WIDTH = 8;
    localparam int I_WIDTH = 8;
    localparam int G_BITS  = 4;
    localparam int N_COLS  = 4;
    localparam int W       = F_WIDTH + I_WIDTH;
    localparam int A       = W + G_BITS;

    logic              clk_i = 1'b0;
    logic              oreg_rst_i;
    logic              capture_i;
    logic [N_COLS*A-1:0] psum_i;
    logic              capture_ready_o;
    logic [W-1:0]      out_data_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              out_last_o;
    logic              frame_done_o;
    logic              overrun_o;

    int errors = 0;
    int checks = 0;

    oreg_drain_ctrl #(
        .F_WIDTH (F_WIDTH),
        .I_WIDTH (I_WIDTH),
        .G_BITS  (G_BITS),
        .N_COLS  (N_COLS)
    ) dut (
        .clk_i           (clk_i),
        .oreg_rst_i      (oreg_rst_i),
        .capture_i       (capture_i),
        .psum_i          (psum_i),
        .capture_ready_o (capture_ready_o),
        .out_data_o      (out_data_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_last_o      (out_last_o),
        .frame_done_o    (frame_done_o),
        .overrun_o       (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle capture (column 0 first) and returns at the sample point of cycle t+1
    task automatic applyStimulus(input int c0, input int c1, input int c2, input int c3);
        psum_i    = {A'(c3), A'(c2), A'(c1), A'(c0)};
        capture_i = 1'b1;
        @(negedge clk_i);
        capture_i = 1'b0;
    endtask

    task automatic checkWord(input string tag, input int exp, input logic lastExp);
        checkOutput({tag, ".valid"}, out_valid_o, 1);
        checkOutput({tag, ".data"}, $signed(out_data_o), exp);
        checkOutput({tag, ".last"}, out_last_o, lastExp);
        checkOutput({tag, ".done"}, frame_done_o, 0);
        checkOutput({tag, ".rdy"}, capture_ready_o, 0);
        @(negedge clk_i);
    endtask

    task automatic checkFrameDone(input string tag);
        checkOutput({tag, ".done"}, frame_done_o, 1);
        checkOutput({tag, ".valid"}, out_valid_o, 0);
        checkOutput({tag, ".last"}, out_last_o, 0);
        checkOutput({tag, ".rdy"}, capture_ready_o, 1);
        checkOutput({tag, ".data"}, $signed(out_data_o), 0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".valid"}, out_valid_o, 0);
        checkOutput({tag, ".last"}, out_last_o, 0);
        checkOutput({tag, ".data"}, $signed(out_data_o), 0);
        checkOutput({tag, ".done"}, frame_done_o, 0);
        checkOutput({tag, ".ovr"}, overrun_o, 0);
        checkOutput({tag, ".rdy"}, capture_ready_o, 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        oreg_rst_i  = 1'b1;
        capture_i   = 1'b0;
        out_ready_i = 1'b1;
        psum_i      = '0;
        @(negedge clk_i);
        checkResetState("reset");
        oreg_rst_i = 1'b0;
        @(negedge clk_i);
        checkResetState("idle");

        $display("[TB] basic drain");
        applyStimulus(100, 0, -3, 40);
        checkWord("basic.w0", 100, 1'b0);
        checkWord("basic.w1", 0, 1'b0);
        checkWord("basic.w2", -3, 1'b0);
        checkWord("basic.w3", 40, 1'b1);
        checkFrameDone("basic");
        @(negedge clk_i);
        checkOutput("basic.donePulse", frame_done_o, 0);

        $display("[TB] saturation");
        applyStimulus(40000, -40000, 32767, -32768);
        checkWord("sat.w0", 32767, 1'b0);
        checkWord("sat.w1", -32768, 1'b0);
        checkWord("sat.w2", 32767, 1'b0);
        checkWord("sat.w3", -32768, 1'b1);
        checkFrameDone("sat");
        @(negedge clk_i);

        $display("[TB] backpressure");
        applyStimulus(11, 22, 33, 44);
        checkWord("bp.w0", 11, 1'b0);
        out_ready_i = 1'b0;
        checkWord("bp.stall0", 22, 1'b0);
        checkWord("bp.stall1", 22, 1'b0);
        checkWord("bp.stall2", 22, 1'b0);
        out_ready_i = 1'b1;
        checkWord("bp.w1", 22, 1'b0);
        checkWord("bp.w2", 33, 1'b0);
        checkWord("bp.w3", 44, 1'b1);
        checkFrameDone("bp");
        @(negedge clk_i);

        $display("[TB] overrun and back-to-back");
        applyStimulus(5, 6, 7, 8);
        checkWord("ovr.w0", 5, 1'b0);
        checkWord("ovr.w1", 6, 1'b0);
        checkOutput("ovr.before", overrun_o, 0);
        psum_i    = {A'(99), A'(98), A'(97), A'(96)};
        capture_i = 1'b1;
        checkWord("ovr.w2", 7, 1'b0);
        capture_i = 1'b0;
        checkOutput("ovr.set", overrun_o, 1);
        checkWord("ovr.w3", 8, 1'b1);
        checkFrameDone("ovr");
        checkOutput("ovr.sticky", overrun_o, 1);
        applyStimulus(1, 2, 3, 4);
        checkWord("b2b.w0", 1, 1'b0);
        checkWord("b2b.w1", 2, 1'b0);
        checkWord("b2b.w2", 3, 1'b0);
        checkWord("b2b.w3", 4, 1'b1);
        checkFrameDone("b2b");
        checkOutput("b2b.sticky", overrun_o, 1);
        @(negedge clk_i);

        $display("[TB] reset mid-drain");
        applyStimulus(-1, -2, -3, -4);
        checkWord("rst.w0", -1, 1'b0);
        checkOutput("rst.w1", $signed(out_data_o), -2);
        #2 oreg_rst_i = 1'b1;
        #1 checkResetState("rst.async");
        @(negedge clk_i);
        oreg_rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            checkOutput("rst.noDone", frame_done_o, 0);
            checkOutput("rst.noValid", out_valid_o, 0);
        end
        applyStimulus(7, -7, 300, -300);
        checkWord("post.w0", 7, 1'b0);
        checkWord("post.w1", -7, 1'b0);
        checkWord("post.w2", 300, 1'b0);
        checkWord("post.w3", -300, 1'b1);
        checkFrameDone("post");
        checkOutput("post.ovr", overrun_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
